// File: rtl/pnr_sysbus_pkg.sv
// Shared definitions for the PNR system-bus initiator: bus geometry and FSM state encoding.
package pnr_sysbus_pkg;

  localparam int SYS_AW = 32;
  localparam int SYS_DW = 32;
  localparam logic [SYS_AW-1:0] SYS_ADDR_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WDAT     = 3'd1,
    ST_STROBE   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_RDOUT    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/pnr_ack_timer.sv
// Ack timeout counter: clear restarts the count, enable advances it, expired flags the last wait cycle.
module pnr_ack_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // The strobe cycle itself counts as the first elapsed cycle, so clear loads 1.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= CW'(1);
    end else if (en_i && (cnt != CW'(TIMEOUT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Expired while waiting when the coming edge completes TIMEOUT cycles since the strobe.
  assign expired_o = en_i && (cnt >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/pnr_sysbus_initiator.sv
// Sys-bus initiator: converts a valid/ready command stream into single or incrementing bursts
// with per-beat ack timeout and abort on slave error.
module pnr_sysbus_initiator
  import pnr_sysbus_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int LEN_W   = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [SYS_AW-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [SYS_DW-1:0] wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [SYS_DW-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              timeout_o,
  output logic [SYS_AW-1:0] sys_addr_o,
  output logic [SYS_DW-1:0] sys_wdata_o,
  output logic              sys_wen_o,
  output logic              sys_ren_o,
  input  logic [SYS_DW-1:0] sys_rdata_i,
  input  logic              sys_err_i,
  input  logic              sys_ack_i
);

  state_e            state_q, state_d;
  logic              we_q;
  logic [LEN_W-1:0]  beats_q;
  logic [SYS_AW-1:0] addr_q;
  logic [SYS_DW-1:0] wdata_q, rdata_q;
  logic              err_q, timeout_q;
  logic              accept, last_beat;
  logic              tmr_clr, tmr_en, tmr_expired;

  assign accept    = (state_q == ST_IDLE) && cmd_valid_i;
  assign last_beat = (beats_q == '0);

  pnr_ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      ST_IDLE:     if (cmd_valid_i) state_d = cmd_we_i ? ST_WDAT : ST_STROBE;
      ST_WDAT:     if (wr_valid_i) state_d = ST_STROBE;
      ST_STROBE: begin
        tmr_clr = 1'b1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        tmr_en = 1'b1;
        // An ack arriving on the expiry cycle still completes the beat.
        if (sys_ack_i) begin
          if (sys_err_i)      state_d = ST_DONE;
          else if (!we_q)     state_d = ST_RDOUT;
          else if (last_beat) state_d = ST_DONE;
          else                state_d = ST_WDAT;
        end else if (tmr_expired) begin
          state_d = ST_DONE;
        end
      end
      ST_RDOUT:    if (rd_ready_i) state_d = last_beat ? ST_DONE : ST_STROBE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      we_q      <= 1'b0;
      beats_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          we_q      <= cmd_we_i;
          addr_q    <= cmd_addr_i;
          beats_q   <= cmd_len_i;
          err_q     <= 1'b0;
          timeout_q <= 1'b0;
        end
        ST_WDAT: if (wr_valid_i) wdata_q <= wr_data_i;
        ST_WAIT_ACK: begin
          if (sys_ack_i) begin
            if (sys_err_i) begin
              err_q <= 1'b1;
            end else if (!we_q) begin
              rdata_q <= sys_rdata_i;
            end else if (!last_beat) begin
              addr_q  <= addr_q + SYS_ADDR_STEP;
              beats_q <= beats_q - LEN_W'(1);
            end
          end else if (tmr_expired) begin
            timeout_q <= 1'b1;
          end
        end
        ST_RDOUT: if (rd_ready_i && !last_beat) begin
          addr_q  <= addr_q + SYS_ADDR_STEP;
          beats_q <= beats_q - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshakes and strobes decode straight from the state so an async reset kills them at once.
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign wr_ready_o  = (state_q == ST_WDAT);
  assign rd_valid_o  = (state_q == ST_RDOUT);
  assign done_o      = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign sys_wen_o   = (state_q == ST_STROBE) && we_q;
  assign sys_ren_o   = (state_q == ST_STROBE) && !we_q;
  assign sys_addr_o  = addr_q;
  assign sys_wdata_o = wdata_q;
  assign rd_data_o   = rdata_q;
  assign err_o       = err_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pnr_sysbus_initiator.sv
// Bench for pnr_sysbus_initiator: directed scenarios plus randomized bursts against a burst-level model.
module tb_pnr_sysbus_initiator;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i;
  logic [3:0]  cmd_len_i;
  logic        wr_valid_i, wr_ready_o;
  logic [31:0] wr_data_i;
  logic        rd_valid_o, rd_ready_i;
  logic [31:0] rd_data_o;
  logic        busy_o, done_o, err_o, timeout_o;
  logic [31:0] sys_addr_o, sys_wdata_o;
  logic        sys_wen_o, sys_ren_o;
  logic [31:0] sys_rdata_i = 32'h0;
  logic        sys_err_i = 1'b0;
  logic        sys_ack_i = 1'b0;

  pnr_sysbus_initiator #(.TIMEOUT(TO), .LEN_W(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .timeout_o(timeout_o),
    .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o),
    .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o),
    .sys_rdata_i(sys_rdata_i), .sys_err_i(sys_err_i), .sys_ack_i(sys_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave model: configurable ack delay (0 = never acks), error on one strobe index of a command.
  int          ack_delay = 1;
  int          err_idx   = -1;
  int          cmd_base  = 0;
  int          pend      = 0;
  bit          prev_stb  = 0;
  int          stab_bad  = 0;
  int          b2b_bad   = 0;
  logic [31:0] s_addr[$];
  logic [31:0] s_wdata[$];
  bit          s_we[$];
  int          s_cyc[$];
  logic [31:0] pre[logic [31:0]];

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return pre.exists(a) ? pre[a] : (a ^ 32'h5A5A_C3C3);
  endfunction

  always @(negedge clk_i) begin
    sys_ack_i = 1'b0;
    sys_err_i = 1'b0;
    if (!rstn_i) begin
      pend = 0;
      prev_stb = 0;
    end else begin
      if (pend > 0) begin
        if (sys_addr_o !== s_addr[$] || (s_we[$] && sys_wdata_o !== s_wdata[$]) ||
            sys_wen_o || sys_ren_o) stab_bad++;
        pend--;
        if (pend == 0) begin
          sys_ack_i   = 1'b1;
          sys_err_i   = ((s_addr.size() - 1 - cmd_base) == err_idx);
          sys_rdata_i = slave_rd(s_addr[$]);
        end
      end
      if (sys_wen_o || sys_ren_o) begin
        if (prev_stb) b2b_bad++;
        s_addr.push_back(sys_addr_o);
        s_wdata.push_back(sys_wdata_o);
        s_we.push_back(sys_wen_o);
        s_cyc.push_back(cyc);
        pend = ack_delay;
      end
      prev_stb = sys_wen_o || sys_ren_o;
    end
  end

  logic [31:0] wr_q[$];
  logic [31:0] exp_wd[$];
  logic [31:0] rd_got[$];
  bit          rand_ready = 0;
  bit          done_seen, got_err, got_to;
  int          acc_cyc, done_cyc;

  task automatic run_cmd(input bit we, input logic [31:0] addr, input logic [3:0] len,
                         input int stall_beat, input int stall_n);
    int n, rbeat, sctr;
    bit take, rtake;
    rd_got.delete();
    done_seen = 0; got_err = 0; got_to = 0;
    cmd_base = s_addr.size();
    exp_wd = wr_q;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_len_i = len;
    n = 0;
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("cmd_ready", cmd_ready_o, 1'b1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    acc_cyc = cyc;
    check("busy_on_accept", {busy_o, err_o, timeout_o}, 3'b100);
    n = 0; rbeat = 0; sctr = 0;
    while (!done_seen && n < 400) begin
      wr_valid_i = (wr_q.size() > 0);
      wr_data_i  = (wr_q.size() > 0) ? wr_q[0] : 32'h0;
      if (rd_valid_o && rbeat == stall_beat && sctr < stall_n) begin
        rd_ready_i = 1'b0;
        sctr++;
        check("no_ren_stall", sys_ren_o, 1'b0);
      end else begin
        rd_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      take  = wr_ready_o && wr_valid_i;
      rtake = rd_valid_o && rd_ready_i;
      if (rtake) rd_got.push_back(rd_data_o);
      if (done_o) begin
        done_seen = 1; done_cyc = cyc; got_err = err_o; got_to = timeout_o;
      end
      @(negedge clk_i);
      if (take) void'(wr_q.pop_front());
      if (rtake) rbeat++;
      n++;
    end
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    wr_q.delete();
    check("done_seen", done_seen, 1'b1);
    check("idle_after_done", {cmd_ready_o, busy_o, done_o}, 3'b100);
  endtask

  // Burst-level expectation: which beats reach the bus, with what address/data, and how it ends.
  task automatic verify_cmd(input string tag, input bit we, input logic [31:0] addr, input int len);
    int  n, nrd, nstb;
    bit  exp_to, exp_err;
    exp_to  = (ack_delay == 0) || (ack_delay >= TO);
    exp_err = !exp_to && (err_idx >= 0) && (err_idx <= len);
    n       = exp_to ? 1 : (exp_err ? err_idx + 1 : len + 1);
    nstb    = s_addr.size() - cmd_base;
    check({tag, "_nstb"}, nstb, n);
    for (int i = 0; i < n && i < nstb; i++) begin
      check({tag, "_addr"}, s_addr[cmd_base + i], addr + 32'(4 * i));
      check({tag, "_we"}, s_we[cmd_base + i], we);
      if (we) check({tag, "_wdata"}, s_wdata[cmd_base + i], exp_wd[i]);
    end
    check({tag, "_err"}, {got_err, err_o}, {exp_err, exp_err});
    check({tag, "_tmo"}, {got_to, timeout_o}, {exp_to, exp_to});
    if (!we) begin
      nrd = (exp_to || exp_err) ? n - 1 : n;
      check({tag, "_nrd"}, rd_got.size(), nrd);
      for (int i = 0; i < nrd && i < rd_got.size(); i++)
        check({tag, "_rdata"}, rd_got[i], slave_rd(addr + 32'(4 * i)));
    end
    check({tag, "_hold"}, stab_bad, 0);
    check({tag, "_b2b"}, b2b_bad, 0);
  endtask

  initial begin
    bit          rwe;
    logic [31:0] raddr;
    logic [3:0]  rlen;

    rstn_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = 32'h0; cmd_len_i = 4'h0;
    wr_valid_i = 1'b0; wr_data_i = 32'h0; rd_ready_i = 1'b0;
    #1 rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset_ctrl", {cmd_ready_o, wr_ready_o, rd_valid_o, busy_o, done_o,
                         err_o, timeout_o, sys_wen_o, sys_ren_o}, 9'b1_0000_0000);
    check("reset_addr", sys_addr_o, 32'h0);
    check("reset_wdata", sys_wdata_o, 32'h0);
    check("reset_rdata", rd_data_o, 32'h0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // single write
    ack_delay = 1; err_idx = -1;
    wr_q = '{32'h0000_1ABC};
    run_cmd(1'b1, 32'h4, 4'd0, -1, 0);
    verify_cmd("t1", 1'b1, 32'h4, 0);
    check("t1_wen_lat", s_cyc[cmd_base] - acc_cyc, 1);
    check("t1_done_lat", done_cyc - acc_cyc, 3);

    // 3-beat read with a consumer stall on beat 1
    pre[32'h4] = 32'h11; pre[32'h8] = 32'h22; pre[32'hC] = 32'h33;
    run_cmd(1'b0, 32'h4, 4'd2, 1, 3);
    verify_cmd("t2", 1'b0, 32'h4, 2);
    check("t2_ren_lat", s_cyc[cmd_base] - acc_cyc, 0);

    // silent slave
    ack_delay = 0;
    run_cmd(1'b0, 32'h40, 4'd3, -1, 0);
    verify_cmd("t3", 1'b0, 32'h40, 3);
    check("t3_tmo_lat", done_cyc - s_cyc[cmd_base], TO);

    // error on beat 1 of a 4-beat write
    ack_delay = 1; err_idx = 1;
    wr_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_cmd(1'b1, 32'h200, 4'd3, -1, 0);
    verify_cmd("t4", 1'b1, 32'h200, 3);

    // address wrap
    err_idx = -1;
    wr_q = '{32'hBEEF_0001, 32'hBEEF_0002};
    run_cmd(1'b1, 32'hFFFF_FFFC, 4'd1, -1, 0);
    verify_cmd("t6", 1'b1, 32'hFFFF_FFFC, 1);

    // async reset while waiting for ack
    ack_delay = 0;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h100; cmd_len_i = 4'd0;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    check("t5_ren", sys_ren_o, 1'b1);
    @(negedge clk_i);
    check("t5_waiting", {busy_o, sys_ren_o}, 2'b10);
    #1 rstn_i = 1'b0;
    #1 check("t5_rst_now", {sys_wen_o, sys_ren_o, busy_o, cmd_ready_o}, 4'b0001);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("t5_after_rel", {cmd_ready_o, busy_o}, 2'b10);
    ack_delay = 1;
    wr_q = '{32'h5555_AAAA};
    run_cmd(1'b1, 32'h80, 4'd0, -1, 0);
    verify_cmd("t5_next", 1'b1, 32'h80, 0);

    // randomized bursts
    rand_ready = 1;
    for (int it = 0; it < 24; it++) begin
      rwe       = 1'($urandom_range(0, 1));
      raddr     = $urandom() & 32'hFFFF_FFFC;
      rlen      = 4'($urandom_range(0, 7));
      ack_delay = $urandom_range(1, 9);
      err_idx   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(rlen)) : -1;
      wr_q.delete();
      if (rwe) for (int b = 0; b <= int'(rlen); b++) wr_q.push_back($urandom());
      run_cmd(rwe, raddr, rlen, -1, 0);
      verify_cmd("rnd", rwe, raddr, int'(rlen));
    end

    repeat (3) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
